cmp_seq: RTL

- Multi-cycle, parametrised comparator. Generalises the fixed 32-bit equality and nonzero-equality comparators to any width.
- Adds modes: EQ, NE, unsigned/signed LT/GE, EQ_NONZERO.
- Scans operands CHUNK bits per cycle, MSB-first, and stops early at the first differing chunk.
- Used by the multi-cycle datapath for branch resolution and hazard checks where a full-width single-cycle compare would limit timing.

---
 rtl/cmp_pkg.sv | 37 +++
 rtl/cmp_chunk.sv | 17 +
 rtl/cmp_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the chunked multi-cycle comparator: mode codes,
// FSM states and the mode-to-result mapping.
package cmp_pkg;

    localparam logic [2:0] CMP_EQ   = 3'd0;
    localparam logic [2:0] CMP_NE   = 3'd1;
    localparam logic [2:0] CMP_LTU  = 3'd2;
    localparam logic [2:0] CMP_LTS  = 3'd3;
    localparam logic [2:0] CMP_GEU  = 3'd4;
    localparam logic [2:0] CMP_GES  = 3'd5;
    localparam logic [2:0] CMP_EQNZ = 3'd6;
    localparam logic [2:0] CMP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic mode_y(input logic [2:0] m, input logic eq,
                                    input logic lt, input logic nz);
        logic y;
        y = 1'b0;
        case (m)
            CMP_EQ:   y = eq;
            CMP_NE:   y = !eq;
            CMP_LTU,
            CMP_LTS:  y = lt;
            CMP_GEU,
            CMP_GES:  y = !lt;
            CMP_EQNZ: y = eq && nz;
            default:  y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// One chunk of the comparison: equality plus signed/unsigned less-than.
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         eq,
    output logic         lt
);

    always_comb begin
        eq = (a == b);
        lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);
    end

endmodule

// File: rtl/cmp_seq.sv
// Multi-cycle comparator: walks the operands CHUNK bits per cycle, MSB first,
// and finishes at the first differing chunk.
module cmp_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             Y,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b;
    logic [2:0]       r_mode;
    logic [IW-1:0]    r_idx;
    logic             r_nz;
    logic             r_busy, r_done, r_y, r_eq, r_lt;

    logic [CHUNK-1:0] w_ca, w_cb;
    logic             w_signed, w_ceq, w_clt, w_nz_final;

    assign w_ca = CHUNK'(r_a >> (int'(r_idx) * CHUNK));
    assign w_cb = CHUNK'(r_b >> (int'(r_idx) * CHUNK));
    // Only the sign-carrying top chunk is compared signed.
    assign w_signed   = (r_idx == IDX_TOP) && (r_mode == CMP_LTS || r_mode == CMP_GES);
    assign w_nz_final = r_nz | (|w_ca);

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .a         (w_ca),
        .b         (w_cb),
        .is_signed (w_signed),
        .eq        (w_ceq),
        .lt        (w_clt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= CMP_EQ;
            r_idx   <= '0;
            r_nz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_mode  <= mode;
                        r_idx   <= IDX_TOP;
                        r_nz    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!w_ceq) begin
                        r_eq    <= 1'b0;
                        r_lt    <= w_clt;
                        r_y     <= mode_y(r_mode, 1'b0, w_clt, 1'b0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_idx != '0) begin
                        r_nz  <= w_nz_final;
                        r_idx <= r_idx - 1'b1;
                    end else begin
                        r_eq    <= 1'b1;
                        r_lt    <= 1'b0;
                        r_y     <= mode_y(r_mode, 1'b1, 1'b0, w_nz_final);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Y    = r_y;
    assign eq   = r_eq;
    assign lt   = r_lt;

endmodule
